// File: rtl/mac_accumulator_if.sv
// mac_accumulator_if: operand-in and result-out valid/ready handshakes of the MAC stage.
interface mac_accumulator_if #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_acc;
   logic              overflow;
   modport master (output in_valid, in_a, in_b, out_ready,
                   input  in_ready, out_valid, out_acc, overflow);
   modport slave  (input  in_valid, in_a, in_b, out_ready,
                   output in_ready, out_valid, out_acc, overflow);
endinterface

// File: rtl/mac_accumulator.sv
// mac_accumulator: iterative shift-add multiplier feeding an N_TERMS accumulator with
// valid/ready operand input and result output.
module eightbit_adder (
   input  logic [7:0] i_a,
   input  logic [7:0] i_b,
   input  logic       i_ci,
   output logic [7:0] o_s,
   output logic       o_co
);
   assign {o_co, o_s} = {1'b0, i_a} + {1'b0, i_b} + {8'd0, i_ci};
endmodule

module mac_accumulator #(
   parameter int DATA_W  = 8,
   parameter int ACC_W   = 16,
   parameter int N_TERMS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   mac_accumulator_if.slave    bus
);
   localparam int PW = 2 * DATA_W;
   localparam int NS = (DATA_W + 7) / 8;
   localparam int SW = NS * 8;
   localparam int CW = $clog2(N_TERMS + 1);
   localparam int KW = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {IDLE, MUL, ACC, OUT} state_t;

   state_t            r_state, w_next;
   logic [DATA_W-1:0] r_a, r_b;
   logic [PW-1:0]     r_prod;
   logic [ACC_W-1:0]  r_acc, r_out_acc;
   logic [CW-1:0]     r_cnt;
   logic [KW-1:0]     r_step;
   logic              r_ovf;
   logic [SW-1:0]     w_x, w_y, w_s;
   logic [NS:0]       w_c;
   logic [SW:0]       w_full;
   logic [ACC_W:0]    w_acc_sum;
   logic              w_accept, w_take, w_last, w_done;

   // Upper half of the partial product plus the gated multiplicand, rippled through byte slices
   assign w_x    = SW'(r_prod[PW-1:DATA_W]);
   assign w_y    = r_b[0] ? SW'(r_a) : '0;
   assign w_c[0] = 1'b0;
   for (genvar g = 0; g < NS; g++) begin : g_add
      eightbit_adder u_add (
         .i_a  (w_x[8*g +: 8]),
         .i_b  (w_y[8*g +: 8]),
         .i_ci (w_c[g]),
         .o_s  (w_s[8*g +: 8]),
         .o_co (w_c[g+1])
      );
   end
   assign w_full    = {w_c[NS], w_s};
   assign w_acc_sum = {1'b0, r_acc} + (ACC_W+1)'(r_prod);

   assign bus.in_ready  = (r_state == IDLE) & ~clear;
   assign bus.out_valid = (r_state == OUT);
   assign bus.out_acc   = r_out_acc;
   assign bus.overflow  = r_ovf;

   assign w_accept = bus.in_valid & bus.in_ready;
   assign w_take   = bus.out_valid & bus.out_ready;
   assign w_last   = (r_step == KW'(DATA_W - 1));
   assign w_done   = (r_cnt == CW'(N_TERMS - 1));

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_accept ? MUL : IDLE;
         MUL:     w_next = w_last ? ACC : MUL;
         ACC:     w_next = w_done ? OUT : IDLE;
         OUT:     w_next = w_take ? IDLE : OUT;
         default: w_next = IDLE;
      endcase
      if (clear) w_next = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a       <= '0;
         r_b       <= '0;
         r_prod    <= '0;
         r_step    <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_ovf     <= 1'b0;
         r_out_acc <= '0;
      end else if (clear) begin
         r_step    <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_ovf     <= 1'b0;
         r_out_acc <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_accept) begin
               r_a    <= bus.in_a;
               r_b    <= bus.in_b;
               r_prod <= '0;
               r_step <= '0;
            end
            MUL: begin
               r_prod <= {w_full[DATA_W:0], r_prod[DATA_W-1:1]};
               r_b    <= r_b >> 1;
               r_step <= r_step + 1'b1;
            end
            ACC: begin
               r_acc <= w_acc_sum[ACC_W-1:0];
               r_ovf <= r_ovf | w_acc_sum[ACC_W];
               r_cnt <= r_cnt + 1'b1;
               if (w_done) r_out_acc <= w_acc_sum[ACC_W-1:0];
            end
            OUT: if (w_take) begin
               r_acc     <= '0;
               r_cnt     <= '0;
               r_ovf     <= 1'b0;
               r_out_acc <= '0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
Sequential multiply-accumulate stage of the MAC unit. It accepts unsigned 8-bit operand pairs over a valid/ready handshake and forms each product with an iterative shift-add loop built on eightbit_adder slices. It sums N_TERMS products into an accumulator and presents the result downstream over a second valid/ready handshake.

Parameters:
DATA_W, 8, operand width; the shift-add datapath is built from eightbit_adder slices.
ACC_W, 16, accumulator and result width; must be at least 2*DATA_W.
N_TERMS, 4, products summed per result; must be at least 1.

Ports:
clk  in  1  single system clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
clear  in  1  synchronous abort-and-zero.
in_valid  in  1  operand pair valid.
in_ready  out  1  block can accept an operand pair.
in_a  in  DATA_W  multiplicand, unsigned.
in_b  in  DATA_W  multiplier, unsigned.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
out_acc  out  ACC_W  accumulated sum.
overflow  out  1  sticky flag: accumulation wrapped since the last result.

Behaviour:
- Reset is asynchronous and active-low; one clock, clk. While rst_n=0, the block forces these values:
  - state=IDLE, accumulator=0, term count=0, overflow=0, out_valid=0, out_acc=0.
  - in_ready=1, provided clear=0.
- in_ready = (state==IDLE) & ~clear, decoded from state.
- An input is accepted on a rising edge where in_valid & in_ready=1. On that edge the block latches in_a and in_b, zeroes the product register and moves to MUL.
- MUL lasts exactly DATA_W cycles; there is one bit step per cycle, LSB first.
  - Per step: if the current multiplier bit is 1, add the multiplicand to the product; then shift.
  - The product is 2*DATA_W bits. Arithmetic is unsigned with no rounding.
- ACC lasts 1 cycle.
  - accumulator <= (accumulator + zero-extended product) mod 2^ACC_W.
  - If that add carries out of ACC_W, overflow <= 1. The flag is sticky.
  - The term count increments. If the count reaches N_TERMS, go to OUT; otherwise go to IDLE.
- OUT state:
  - out_valid=1. out_acc and overflow are held stable while out_ready=0.
  - On an edge with out_valid & out_ready: accumulator, count and overflow clear to 0, out_valid drops and the state returns to IDLE.
- Latency per term: the accepting edge plus DATA_W MUL edges plus 1 ACC edge.
  - For the last term, out_valid rises after the (DATA_W+2)th edge counted from the accepting edge, inclusive.
  - With DATA_W=8 that is 10 edges.
- Throughput: one term per DATA_W+2 cycles at most; there is no overlap between terms.
- out_acc is a registered output. It is 0 outside OUT.
- clear=1 on an edge, in any state: abort the current term, zero accumulator/count/overflow/out_valid, go to IDLE.
  - clear has priority over the input handshake, the output handshake and the ACC update.
- Zero operands still take the full MUL/ACC latency and count as terms.
- Count wrap cannot occur: the count is sized to hold N_TERMS and always returns to 0 through OUT or clear.
- Reset asserted mid-operation, in any state: all outputs return to their reset values immediately, without waiting for a clock edge.
- Products in flight are discarded on reset or clear.

Test Plan:
1. Reset with clear=0: in_ready=1, out_valid=0, out_acc=0, overflow=0. Release rst_n, hold in_valid=0 for 5 cycles -> outputs unchanged.
2. Terms (3,4),(5,6),(7,8),(9,10) with out_ready=1 -> out_acc=188, overflow=0. out_valid rises exactly 10 edges after the 4th accepting edge, for 1 cycle. in_ready=0 throughout each MUL/ACC.
3. Terms 4x(255,255) -> out_acc=63492 (260100 mod 65536), overflow=1. The flag sets on the 2nd term's ACC edge and stays 1 until the output handshake.
4. Terms (0,200),(200,0),(1,1),(2,2); out_ready held 0 for 6 cycles after out_valid -> out_acc=5 stable and in_ready=0 meanwhile. After the handshake edge: out_valid=0, in_ready=1, and the next four (1,1) terms give 4, proving the accumulator cleared.
5. Accept (10,10) then (20,20). Assert clear for 1 cycle during the 3rd term's MUL step 3 -> state IDLE, in_ready=1 next cycle. Then 4x(1,1) -> out_acc=4, overflow=0.
6. Feed 3x(255,255) so overflow=1. Pull rst_n low during the 4th term's ACC cycle -> out_valid, out_acc and overflow drop to 0 before the next edge. After release, 4x(2,3) -> out_acc=24.
